// File: rtl/deconv_sram_pkg.sv
// Shared constants for the deconvolution kernel SRAM bank: read FSM encodings
// and the channel-select width helper.
package deconv_sram_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // A single channel still needs one select bit so port widths stay legal.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/ram_sync_1rw1r.sv
// Synchronous RAM with one read/write port and one read-only port sharing a
// single registered read-data output; contents are never reset.
module ram_sync_1rw1r #(
    parameter int DATA_WIDTH = 16,
    parameter int AW         = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  rwen,
    input  logic [AW-1:0]         rw_addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    input  logic [AW-1:0]         r_addr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int WORDS = 1 << AW;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    // The read-only port wins the output register when both ports read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[rw_addr] <= wdata;
        end
        if (ren) begin
            rdata <= mem[r_addr];
        end else if (rwen && !we) begin
            rdata <= mem[rw_addr];
        end
    end

endmodule

// File: rtl/deconv_kernel_sram_bank_interface.sv
// Multi-channel kernel SRAM bank: per-channel append-only writes and a debug
// readout FSM. Define DECONV_SRAM_OVF_COUNT_EN to add the ovf_count output.
module deconv_kernel_sram_bank_interface
    import deconv_sram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_CH     = 2,
    localparam int CH_W      = ch_width(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wvalid,
    input  logic [CH_W-1:0]       wch,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wready,
    input  logic                  clr,
    input  logic                  debug,
    input  logic                  rd_start,
    input  logic [CH_W-1:0]       rd_ch,
    input  logic                  rd_ready,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rlast,
    output logic                  busy,
    output logic [NUM_CH-1:0]     full,
    output logic                  overflow
`ifdef DECONV_SRAM_OVF_COUNT_EN
    ,
    output logic [15:0]           ovf_count
`endif
);

    localparam int RAM_AW = CH_W + ADDR_WIDTH - 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_FULL = ADDR_WIDTH'(DEPTH);

    logic [ADDR_WIDTH-1:0] wptr [NUM_CH];
    logic [1:0]            state;
    logic [CH_W-1:0]       rd_ch_q;
    logic [ADDR_WIDTH-1:0] length;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [ADDR_WIDTH-1:0] rd_next;
    logic                  rlast_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  ren;
    logic [RAM_AW-1:0]     raddr;
    logic [RAM_AW-1:0]     waddr;
    logic                  in_idle;
    logic                  clr_fire;
    logic                  write_fire;
    logic                  drop;
    logic                  start_ok;

    assign wready     = !debug && !clr;
    assign in_idle    = (state == ST_IDLE);
    assign clr_fire   = clr && in_idle;
    assign write_fire = wvalid && wready && !full[wch];
    assign drop       = wvalid && wready && full[wch];
    assign waddr      = {wch, wptr[wch][ADDR_WIDTH-2:0]};
    assign start_ok   = in_idle && debug && rd_start && (wptr[rd_ch] != '0);
    assign rd_next    = rd_idx + PTR_ONE;

    assign busy   = !in_idle;
    assign rvalid = (state == ST_HOLD);
    assign rlast  = rvalid && rlast_q;
    assign rdata  = rdata_q;

    // Pointers saturate at DEPTH instead of wrapping, so full is a plain compare.
    always_comb begin
        full = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            full[c] = (wptr[c] == PTR_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_fire) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr[c] <= '0;
            end
            overflow <= 1'b0;
        end else begin
            if (write_fire) begin
                wptr[wch] <= wptr[wch] + PTR_ONE;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Reads are only launched on entry to FETCH, so each word costs two cycles.
    always_comb begin
        ren   = 1'b0;
        raddr = {rd_ch_q, rd_idx[ADDR_WIDTH-2:0]};
        if (start_ok) begin
            ren   = 1'b1;
            raddr = {rd_ch, {(ADDR_WIDTH-1){1'b0}}};
        end else if ((state == ST_HOLD) && debug && rd_ready && !rlast_q) begin
            ren   = 1'b1;
            raddr = {rd_ch_q, rd_next[ADDR_WIDTH-2:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            rd_ch_q <= '0;
            length  <= '0;
            rd_idx  <= '0;
            rlast_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        rd_ch_q <= rd_ch;
                        length  <= wptr[rd_ch];
                        rd_idx  <= '0;
                        state   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!debug) begin
                        state <= ST_IDLE;
                    end else begin
                        rdata_q <= ram_rdata;
                        rlast_q <= (rd_idx == length - PTR_ONE);
                        state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!debug) begin
                        state <= ST_IDLE;
                    end else if (rd_ready) begin
                        if (rlast_q) begin
                            state <= ST_IDLE;
                        end else begin
                            rd_idx <= rd_next;
                            state  <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DECONV_SRAM_OVF_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst || clr_fire) begin
            ovf_count <= '0;
        end else if (drop && (ovf_count != 16'hFFFF)) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end
`endif

    ram_sync_1rw1r #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .we      (write_fire),
        .rwen    (1'b0),
        .rw_addr (waddr),
        .wdata   (wdata),
        .ren     (ren),
        .r_addr  (raddr),
        .rdata   (ram_rdata)
    );

endmodule

// File: tb/tb_deconv_kernel_sram_bank_interface.sv
// Self-checking bench for deconv_kernel_sram_bank_interface: a write model feeds
// a scoreboard of expected readout words, plus hand-built corner sequences.
module tb_deconv_kernel_sram_bank_interface;

    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        wvalid;
    logic [0:0]  wch;
    logic [15:0] wdata;
    logic        wready;
    logic        clr;
    logic        debug;
    logic        rd_start;
    logic [0:0]  rd_ch;
    logic        rd_ready;
    logic        rvalid;
    logic [15:0] rdata;
    logic        rlast;
    logic        busy;
    logic [1:0]  full;
    logic        overflow;
`ifdef DECONV_SRAM_OVF_COUNT_EN
    logic [15:0] ovf_count;
    int          model_ovf_cnt;
`endif

    typedef struct {
        logic [15:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic        dbg;
        logic        clr;
        logic [0:0]  ch;
        logic [15:0] data;
        logic        exp_wready;
    } vec_t;

    exp_t        exp_q[$];
    logic [15:0] mq0[$];
    logic [15:0] mq1[$];
    bit          model_ovf;
    vec_t        vecs[8];
    int          n_tests;
    int          n_fail;

    deconv_kernel_sram_bank_interface #(
        .DATA_WIDTH (16),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (12),
        .NUM_CH     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wvalid    (wvalid),
        .wch       (wch),
        .wdata     (wdata),
        .wready    (wready),
        .clr       (clr),
        .debug     (debug),
        .rd_start  (rd_start),
        .rd_ch     (rd_ch),
        .rd_ready  (rd_ready),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .rlast     (rlast),
        .busy      (busy),
        .full      (full),
        .overflow  (overflow)
`ifdef DECONV_SRAM_OVF_COUNT_EN
        ,
        .ovf_count (ovf_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int model_size(input int ch);
        return (ch == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [1:0] model_full();
        return {mq1.size() == DEPTH, mq0.size() == DEPTH};
    endfunction

    task automatic clear_model();
        mq0.delete();
        mq1.delete();
        model_ovf = 1'b0;
`ifdef DECONV_SRAM_OVF_COUNT_EN
        model_ovf_cnt = 0;
`endif
    endtask

    task automatic model_write(input int ch, input logic [15:0] data);
        if (model_size(ch) == DEPTH) begin
            model_ovf = 1'b1;
`ifdef DECONV_SRAM_OVF_COUNT_EN
            if (model_ovf_cnt < 16'hFFFF) model_ovf_cnt++;
`endif
        end else if (ch == 0) begin
            mq0.push_back(data);
        end else begin
            mq1.push_back(data);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic write_word(input int ch, input logic [15:0] data);
        debug  = 1'b0;
        clr    = 1'b0;
        wch    = ch[0:0];
        wdata  = data;
        wvalid = 1'b1;
        model_write(ch, data);
        @(posedge clk);
        #1;
        wvalid = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        debug  = v.dbg;
        clr    = v.clr;
        wch    = v.ch;
        wdata  = v.data;
        wvalid = 1'b1;
        #1;
        check_output("wready", {31'd0, wready}, {31'd0, v.exp_wready});
        if (v.clr) clear_model();
        else if (v.exp_wready) model_write(int'(v.ch), v.data);
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        clr    = 1'b0;
        debug  = 1'b0;
    endtask

    // Readout of one channel against the model; optional latency, stall and clr probes.
    task automatic read_channel(input int ch, input bit timing, input int stall, input int clr_cycle);
        int   n;
        int   got;
        int   last_c;
        bit   done;
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < model_size(ch); i++) begin
            e.data = (ch == 0) ? mq0[i] : mq1[i];
            e.last = (i == model_size(ch) - 1);
            exp_q.push_back(e);
        end
        n        = exp_q.size();
        got      = 0;
        last_c   = 0;
        done     = 1'b0;
        debug    = 1'b1;
        rd_ch    = ch[0:0];
        rd_ready = (stall == 0);
        rd_start = 1'b1;
        if (n == 0) begin
            for (int c = 1; c <= 4; c++) begin
                @(posedge clk);
                #1;
                rd_start = 1'b0;
                check_output("empty busy", {31'd0, busy}, 32'd0);
                check_output("empty rvalid", {31'd0, rvalid}, 32'd0);
            end
        end else begin
            for (int c = 1; c <= 2 * n + 8 + stall && !done; c++) begin
                @(posedge clk);
                #1;
                rd_start = 1'b0;
                clr      = (c == clr_cycle);
                if (rvalid) begin
                    if (exp_q.size() == 0) begin
                        check_output("extra word", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("rdata", {16'd0, rdata}, {16'd0, e.data});
                        check_output("rlast", {31'd0, rlast}, {31'd0, e.last});
                        if (timing) check_output("word spacing", c - last_c, 32'd2);
                        if (stall > 0 && got == 0) begin
                            for (int k = 0; k < stall; k++) begin
                                @(posedge clk);
                                #1;
                                check_output("stall rvalid", {31'd0, rvalid}, 32'd1);
                                check_output("stall rdata", {16'd0, rdata}, {16'd0, e.data});
                            end
                            rd_ready = 1'b1;
                        end
                        last_c = c;
                        got++;
                    end
                end else if (!busy) begin
                    done = 1'b1;
                end
            end
            check_output("word count", got, n);
            check_output("readout done", {31'd0, done}, 32'd1);
        end
        clr      = 1'b0;
        debug    = 1'b0;
        rd_ready = 1'b0;
        rd_start = 1'b0;
    endtask

    task automatic start_and_wait(input int ch);
        bit seen;
        seen     = 1'b0;
        debug    = 1'b1;
        rd_ch    = ch[0:0];
        rd_ready = 1'b0;
        rd_start = 1'b1;
        for (int c = 1; c <= 6 && !seen; c++) begin
            @(posedge clk);
            #1;
            rd_start = 1'b0;
            if (rvalid) seen = 1'b1;
        end
        check_output("rvalid seen", {31'd0, seen}, 32'd1);
        check_output("busy in hold", {31'd0, busy}, 32'd1);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        wvalid   = 1'b0;
        wch      = '0;
        wdata    = '0;
        clr      = 1'b0;
        debug    = 1'b0;
        rd_start = 1'b0;
        rd_ch    = '0;
        rd_ready = 1'b0;
        clear_model();

        vecs[0] = '{dbg: 1'b0, clr: 1'b0, ch: 1'b0, data: 16'h0001, exp_wready: 1'b1};
        vecs[1] = '{dbg: 1'b0, clr: 1'b0, ch: 1'b0, data: 16'h0002, exp_wready: 1'b1};
        vecs[2] = '{dbg: 1'b1, clr: 1'b0, ch: 1'b0, data: 16'h0BAD, exp_wready: 1'b0};
        vecs[3] = '{dbg: 1'b0, clr: 1'b0, ch: 1'b1, data: 16'h1111, exp_wready: 1'b1};
        vecs[4] = '{dbg: 1'b0, clr: 1'b1, ch: 1'b1, data: 16'h2222, exp_wready: 1'b0};
        vecs[5] = '{dbg: 1'b0, clr: 1'b0, ch: 1'b1, data: 16'h3333, exp_wready: 1'b1};
        vecs[6] = '{dbg: 1'b0, clr: 1'b0, ch: 1'b0, data: 16'h4444, exp_wready: 1'b1};
        vecs[7] = '{dbg: 1'b1, clr: 1'b0, ch: 1'b1, data: 16'h5555, exp_wready: 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check_output("reset rvalid", {31'd0, rvalid}, 32'd0);
        check_output("reset rlast", {31'd0, rlast}, 32'd0);
        check_output("reset busy", {31'd0, busy}, 32'd0);
        check_output("reset overflow", {31'd0, overflow}, 32'd0);
        check_output("reset full", {30'd0, full}, 32'd0);
        check_output("reset rdata", {16'd0, rdata}, 32'd0);
        check_output("reset wready", {31'd0, wready}, 32'd1);
`ifdef DECONV_SRAM_OVF_COUNT_EN
        check_output("reset ovf_count", {16'd0, ovf_count}, 32'd0);
`endif
        rst = 1'b0;

        // Pointers cleared by reset: the three written words must vanish.
        for (int i = 1; i <= 3; i++) write_word(0, 16'(i));
        check_output("full after 3", {30'd0, full}, {30'd0, model_full()});
        do_reset();
        check_output("post-rst rvalid", {31'd0, rvalid}, 32'd0);
        check_output("post-rst busy", {31'd0, busy}, 32'd0);
        read_channel(0, 1'b0, 0, 0);

        for (int i = 0; i < 8; i++) apply_stimulus(vecs[i]);
        check_output("gated overflow", {31'd0, overflow}, 32'd0);
        read_channel(1, 1'b1, 0, 0);
        read_channel(0, 1'b1, 0, 0);

        do_reset();
        for (int i = 1; i <= 3; i++) write_word(0, 16'(i));
        read_channel(0, 1'b1, 0, 0);

        write_word(1, 16'h00A1);
        write_word(1, 16'h00A2);
        write_word(1, 16'h00A3);
        read_channel(1, 1'b0, 5, 0);

        read_channel(0, 1'b0, 0, 1);
        read_channel(0, 1'b1, 0, 0);

        start_and_wait(0);
        debug = 1'b0;
        @(posedge clk);
        #1;
        check_output("abort rvalid", {31'd0, rvalid}, 32'd0);
        check_output("abort rlast", {31'd0, rlast}, 32'd0);
        check_output("abort busy", {31'd0, busy}, 32'd0);

        start_and_wait(1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        debug = 1'b0;
        clear_model();
        check_output("rst-abort busy", {31'd0, busy}, 32'd0);
        check_output("rst-abort rvalid", {31'd0, rvalid}, 32'd0);
        check_output("rst-abort rdata", {16'd0, rdata}, 32'd0);
        check_output("rst-abort rlast", {31'd0, rlast}, 32'd0);

        for (int i = 0; i < DEPTH; i++) begin
            write_word(1, 16'(i));
            if (i == DEPTH - 2) check_output("full at 2047", {30'd0, full}, {30'd0, model_full()});
        end
        check_output("full at 2048", {30'd0, full}, 32'd2);
        check_output("no overflow yet", {31'd0, overflow}, 32'd0);
        write_word(1, 16'hFFFF);
        check_output("overflow set", {31'd0, overflow}, {31'd0, model_ovf});
        check_output("full after drop", {30'd0, full}, {30'd0, model_full()});
`ifdef DECONV_SRAM_OVF_COUNT_EN
        check_output("ovf_count", {16'd0, ovf_count}, model_ovf_cnt);
`endif
        write_word(0, 16'h0C0C);
        check_output("ch0 unaffected", {30'd0, full}, 32'd2);
        read_channel(0, 1'b1, 0, 0);
        read_channel(1, 1'b1, 0, 0);

        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        clear_model();
        check_output("clr overflow", {31'd0, overflow}, 32'd0);
        check_output("clr full", {30'd0, full}, 32'd0);
`ifdef DECONV_SRAM_OVF_COUNT_EN
        check_output("clr ovf_count", {16'd0, ovf_count}, 32'd0);
`endif
        read_channel(1, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/deconv_kernel_sram_bank_interface.md
DECONV_KERNEL_SRAM_BANK_INTERFACE -- requirements
Module: deconv_kernel_sram_bank_interface

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning word width.
REQ-002 SHALL have parameter DEPTH, default 2048, meaning words per channel (power of two).
REQ-003 SHALL have parameter ADDR_WIDTH, default 12, meaning per-channel pointer width, equal to log2(DEPTH)+1.
REQ-004 SHALL have parameter NUM_CH, default 2, meaning channel count (power of two, >=2), e.g. magnitude/phase.
REQ-005 SHALL have ports: clk in 1 (clock); rst in 1 (reset).
REQ-006 SHALL have ports: wvalid in 1 (write request); wch in CH_W (write channel); wdata in DATA_WIDTH (write data); wready out 1 (write accepted).
REQ-007 SHALL have ports: clr in 1 (clear all pointers and flags); debug in 1 (debug readout mode).
REQ-008 SHALL have ports: rd_start in 1 (begin readout); rd_ch in CH_W (readout channel); rd_ready in 1 (consumer accepts word).
REQ-009 SHALL have ports: rvalid out 1; rdata out DATA_WIDTH; rlast out 1 (final word); busy out 1 (readout active).
REQ-010 SHALL have ports: full out NUM_CH (per-channel full); overflow out 1 (sticky dropped-write flag).
REQ-011 SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-012 SHALL store all channels in one ram_sync_1rw1r of NUM_CH*DEPTH words, addressed {channel, pointer[ADDR_WIDTH-2:0]}.
REQ-013 SHALL drive wready = !debug && !clr.
REQ-014 SHALL, on wvalid && wready && !full[wch], write wdata at wptr[wch] and increment wptr[wch] the same cycle.
REQ-015 SHALL assert full[c] combinationally when wptr[c] == DEPTH; the pointer SHALL NOT wrap.
REQ-016 SHALL drop a write to a full channel, leave its pointer unchanged, and set overflow from the next cycle.
REQ-017 SHALL, on clr with the FSM in IDLE, zero all write pointers and overflow the next cycle; clr during a readout SHALL be ignored.
REQ-018 SHALL implement read FSM states IDLE, FETCH and HOLD, with busy = (state != IDLE).
REQ-019 SHALL, in IDLE with debug && rd_start, latch rd_ch and length = wptr[rd_ch]: if length is 0, stay in IDLE with no rvalid; otherwise issue a read of address 0 and enter FETCH.
REQ-020 SHALL capture the SRAM output into the rdata register in FETCH and enter HOLD; rvalid SHALL be 1 in HOLD only, so rvalid rises 2 cycles after the accepted rd_start.
REQ-021 SHALL hold rdata and rvalid stable in HOLD until rd_ready; rlast SHALL be 1 when the held word index == length-1.
REQ-022 SHALL, on an rvalid && rd_ready handshake, go to IDLE if rlast, else read the next address and go to FETCH.
REQ-023 SHALL, on debug deassertion in FETCH or HOLD, abort to IDLE next cycle with rvalid=0 and rlast=0.
REQ-024 SHALL ignore rd_start while busy.

Reset
REQ-025 SHALL, on rst, set all pointers to 0, state to IDLE, rvalid/rlast/overflow/busy to 0, and rdata to 0; SRAM contents SHALL NOT be cleared.
REQ-026 SHALL let rst mid-readout terminate the readout in the same reset cycle, with rst taking priority over clr and writes.

Configuration
REQ-027 SHALL, with DECONV_SRAM_OVF_COUNT_EN defined, add an output ovf_count (16-bit) that counts dropped writes, saturates at 0xFFFF, and is cleared by rst/clr.
REQ-028 SHALL, without DECONV_SRAM_OVF_COUNT_EN, omit the ovf_count port and its counter, leaving all other behaviour identical.

Structure
REQ-029 SHALL define CH_W = max(1, log2(NUM_CH)) and the FSM state encodings in a shared package, deconv_sram_pkg.
REQ-030 SHALL instantiate exactly one sub-module, ram_sync_1rw1r, with rwen tied 0 and ren driven only on FETCH entry.

Verification
REQ-031 Reset test: write 3 words to ch0 (0x0001..0x0003) -> wptr0=3, full=0; assert rst -> wptr0=0, rvalid=0.
REQ-032 Readout test: debug=1, rd_start on ch0 with rd_ready held 1 -> rvalid at cycle +2; rdata 0x0001,0x0002,0x0003 every 2 cycles; rlast on 0x0003; then busy=0.
REQ-033 Backpressure test: rd_ready=0 for 5 cycles in HOLD -> rdata and rvalid stable for 5 cycles, no skipped word.
REQ-034 Full/overflow test: write 2049 words to ch1 -> full[1]=1 after 2048 words, overflow=1, and with the macro ovf_count=1; ch0 unaffected.
REQ-035 Edge cases: rd_start on an empty channel -> no rvalid, busy stays 0; debug dropped in HOLD -> IDLE next cycle; clr while busy -> pointers unchanged.
